// File: rtl/proc_pkg.sv
// Shared widths, ALU opcode map and flag bit positions for the accumulator
// processor execution/memory slice.
package proc_pkg;

  localparam int DATA_W   = 16;
  localparam int IM_AW    = 10;
  localparam int DM_AW    = 9;
  localparam int OPC_W    = 6;
  localparam int IM_DEPTH = 2 ** IM_AW;
  localparam int DM_DEPTH = 2 ** DM_AW;

  localparam logic [OPC_W-1:0] OP_ADD = 6'd16;
  localparam logic [OPC_W-1:0] OP_SUB = 6'd17;
  localparam logic [OPC_W-1:0] OP_LSR = 6'd18;
  localparam logic [OPC_W-1:0] OP_LSL = 6'd19;
  localparam logic [OPC_W-1:0] OP_ROR = 6'd20;
  localparam logic [OPC_W-1:0] OP_ROL = 6'd21;
  localparam logic [OPC_W-1:0] OP_MOV = 6'd22;
  localparam logic [OPC_W-1:0] OP_MUL = 6'd23;
  localparam logic [OPC_W-1:0] OP_DIV = 6'd24;
  localparam logic [OPC_W-1:0] OP_MOD = 6'd25;
  localparam logic [OPC_W-1:0] OP_AND = 6'd26;
  localparam logic [OPC_W-1:0] OP_OR  = 6'd27;
  localparam logic [OPC_W-1:0] OP_XOR = 6'd28;
  localparam logic [OPC_W-1:0] OP_NOT = 6'd29;
  localparam logic [OPC_W-1:0] OP_CMP = 6'd30;
  localparam logic [OPC_W-1:0] OP_TST = 6'd31;
  localparam logic [OPC_W-1:0] OP_INC = 6'd32;
  localparam logic [OPC_W-1:0] OP_DEC = 6'd33;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_O = 3;
  localparam int FLAG_W = 4;

endpackage

// File: rtl/alu_core.sv
// Combinational 16-bit ALU with zero/negative/carry/overflow flags.
// CMP and TST compute flags from the internal result but drive a zero output.
module alu_core
  import proc_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [OPC_W-1:0]  i_opcode,
  input  logic              i_store,
  output logic [DATA_W-1:0] o_result,
  output logic [FLAG_W-1:0] o_flags
);

  logic [3:0]        w_amt;
  logic [4:0]        w_inv_amt;
  logic [3:0]        w_lsb_idx;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W:0]   w_inc;
  logic [DATA_W-1:0] w_dec;
  logic [DATA_W-1:0] w_ror;
  logic [DATA_W-1:0] w_rol;
  logic              w_shr_c;
  logic              w_shl_c;

  assign w_amt     = i_b[3:0];
  assign w_inv_amt = 5'd16 - {1'b0, w_amt};
  assign w_lsb_idx = w_amt - 4'd1;
  assign w_sum     = {1'b0, i_a} + {1'b0, i_b};
  // Bit 16 of the zero-extended difference is the unsigned borrow (A < B).
  assign w_diff    = {1'b0, i_a} - {1'b0, i_b};
  assign w_inc     = {1'b0, i_a} + 17'd1;
  assign w_dec     = i_a - 16'd1;
  // A shift by 16 yields zero, so amount 0 degenerates cleanly to A.
  assign w_ror     = (i_a >> w_amt) | (i_a << w_inv_amt);
  assign w_rol     = (i_a << w_amt) | (i_a >> w_inv_amt);
  // Last bit shifted out: bit (n-1) going right, bit (16-n) going left.
  assign w_shr_c   = (w_amt != 4'd0) & i_a[w_lsb_idx];
  assign w_shl_c   = (w_amt != 4'd0) & i_a[w_inv_amt[3:0]];

  logic [DATA_W-1:0] w_res;
  logic              w_c;
  logic              w_o;
  logic              w_valid;
  logic              w_hide;

  // Opcode decode: internal result plus carry/overflow for valid opcodes.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_res   = '0;
    w_c     = 1'b0;
    w_o     = 1'b0;
    w_valid = 1'b1;
    w_hide  = 1'b0;
    case (i_opcode)
      OP_ADD: begin
        w_res = w_sum[DATA_W-1:0];
        w_c   = w_sum[DATA_W];
        w_o   = (i_a[15] == i_b[15]) && (w_sum[15] != i_a[15]);
      end
      OP_SUB, OP_CMP: begin
        w_res  = w_diff[DATA_W-1:0];
        w_c    = w_diff[DATA_W];
        w_o    = (i_a[15] != i_b[15]) && (w_diff[15] != i_a[15]);
        w_hide = (i_opcode == OP_CMP);
      end
      OP_LSR: begin
        w_res = i_a >> w_amt;
        w_c   = w_shr_c;
      end
      OP_LSL: begin
        w_res = i_a << w_amt;
        w_c   = w_shl_c;
      end
      OP_ROR: begin
        w_res = w_ror;
        w_c   = w_shr_c;
      end
      OP_ROL: begin
        w_res = w_rol;
        w_c   = w_shl_c;
      end
      OP_MOV: w_res = i_b;
      OP_MUL: w_res = i_a * i_b;
      OP_DIV: begin
        w_res = (i_b == '0) ? 16'hFFFF : i_a / i_b;
        w_c   = (i_b == '0);
      end
      OP_MOD: begin
        w_res = (i_b == '0) ? i_a : i_a % i_b;
        w_c   = (i_b == '0);
      end
      OP_AND: w_res = i_a & i_b;
      OP_OR:  w_res = i_a | i_b;
      OP_XOR: w_res = i_a ^ i_b;
      OP_NOT: w_res = ~i_a;
      OP_TST: begin
        w_res  = i_a & i_b;
        w_hide = 1'b1;
      end
      OP_INC: begin
        w_res = w_inc[DATA_W-1:0];
        w_c   = w_inc[DATA_W];
        w_o   = (i_a == 16'h7FFF);
      end
      OP_DEC: begin
        w_res = w_dec;
        w_c   = (i_a == '0);
        w_o   = (i_a == 16'h8000);
      end
      default: w_valid = 1'b0;
    endcase
  end

  // Output stage: store pass-through overrides everything, invalid opcodes are silent.
  always_comb begin
    o_result = '0;
    o_flags  = '0;
    if (i_store) begin
      o_result = i_a;
    end else if (w_valid) begin
      o_result        = w_hide ? '0 : w_res;
      o_flags[FLAG_Z] = (w_res == '0);
      o_flags[FLAG_N] = w_res[DATA_W-1];
      o_flags[FLAG_C] = w_c;
      o_flags[FLAG_O] = w_o;
    end
  end

endmodule

// File: rtl/alu_mem_datapath.sv
// Execution/memory slice: instruction memory, ALU and data memory with
// direct load/store and a descending stack.
module alu_mem_datapath
  import proc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              im_en_write,
  input  logic [IM_AW-1:0]  im_address,
  input  logic [DATA_W-1:0] im_data_in,
  output logic [DATA_W-1:0] instruction,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  input  logic [OPC_W-1:0]  alu_opcode,
  input  logic              alu_store,
  output logic [DATA_W-1:0] alu_out,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              flag_o,
  input  logic              dm_load,
  input  logic              dm_store,
  input  logic              dm_push,
  input  logic              dm_pop,
  input  logic [DATA_W-1:0] dm_sp,
  input  logic [DM_AW-1:0]  dm_address,
  output logic [DATA_W-1:0] dm_data_out,
  output logic [DM_AW-1:0]  dm_address_reg
);

  logic [DATA_W-1:0] r_im [0:IM_DEPTH-1];
  logic [DATA_W-1:0] r_dm [0:DM_DEPTH-1];
  logic [FLAG_W-1:0] w_flags;
  logic [DM_AW-1:0]  w_pop_addr;
  logic              w_unused_sp_hi;

  alu_core u_alu_core (
    .i_a      (alu_a),
    .i_b      (alu_b),
    .i_opcode (alu_opcode),
    .i_store  (alu_store),
    .o_result (alu_out),
    .o_flags  (w_flags)
  );

  assign flag_z = w_flags[FLAG_Z];
  assign flag_n = w_flags[FLAG_N];
  assign flag_c = w_flags[FLAG_C];
  assign flag_o = w_flags[FLAG_O];

  // Program download port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    // NOTE: memory arrays get no reset branch, so they map onto plain RAM; only control state is reset.
    if (im_en_write) r_im[im_address] <= im_data_in;
  end

  // Fetch shows the stored word until the write edge updates it.
  assign instruction = r_im[im_address];

  // Data memory write: direct store beats a simultaneous push.
  always_ff @(posedge clk) begin
    if (dm_store)     r_dm[dm_address]        <= alu_out;
    else if (dm_push) r_dm[dm_sp[DM_AW-1:0]] <= alu_out;
  end

  // Stack is descending with SP at the next free slot, so pop reads SP+1 (mod 512).
  assign w_pop_addr     = dm_sp[DM_AW-1:0] + 9'd1;
  assign w_unused_sp_hi = ^dm_sp[DATA_W-1:DM_AW];

  // Data memory read: pop has priority over load; idle reads return zero.
  always_comb begin
    dm_data_out = '0;
    if (dm_pop)       dm_data_out = r_dm[w_pop_addr];
    else if (dm_load) dm_data_out = r_dm[dm_address];
  end

  // Remember the last direct-access address; reset wins over capture.
  always_ff @(posedge clk) begin
    if (reset)                     dm_address_reg <= '0;
    else if (dm_load || dm_store)  dm_address_reg <= dm_address;
  end

endmodule

// File: tb/tb_alu_mem_datapath.sv
// Directed self-checking bench for alu_mem_datapath with hand-computed expectations.
module tb_alu_mem_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        im_en_write;
  logic [9:0]  im_address;
  logic [15:0] im_data_in;
  logic [15:0] instruction;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [5:0]  alu_opcode;
  logic        alu_store;
  logic [15:0] alu_out;
  logic        flag_z, flag_n, flag_c, flag_o;
  logic        dm_load, dm_store, dm_push, dm_pop;
  logic [15:0] dm_sp;
  logic [8:0]  dm_address;
  logic [15:0] dm_data_out;
  logic [8:0]  dm_address_reg;

  int n_checks = 0;
  int n_errors = 0;

  alu_mem_datapath dut (
    .clk            (clk),
    .reset          (reset),
    .im_en_write    (im_en_write),
    .im_address     (im_address),
    .im_data_in     (im_data_in),
    .instruction    (instruction),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_opcode     (alu_opcode),
    .alu_store      (alu_store),
    .alu_out        (alu_out),
    .flag_z         (flag_z),
    .flag_n         (flag_n),
    .flag_c         (flag_c),
    .flag_o         (flag_o),
    .dm_load        (dm_load),
    .dm_store       (dm_store),
    .dm_push        (dm_push),
    .dm_pop         (dm_pop),
    .dm_sp          (dm_sp),
    .dm_address     (dm_address),
    .dm_data_out    (dm_data_out),
    .dm_address_reg (dm_address_reg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and return to the falling edge for driving/sampling.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [3:0] flags();
    return {flag_o, flag_c, flag_n, flag_z};
  endfunction

  // Apply one ALU vector and check result and {O,C,N,Z}.
  task automatic alu_chk(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [5:0] op, input logic st,
                         input logic [15:0] exp_out, input logic [3:0] exp_ocnz);
    alu_a = a; alu_b = b; alu_opcode = op; alu_store = st;
    #1;
    check({tag, " out"}, {16'h0, alu_out}, {16'h0, exp_out});
    check({tag, " ocnz"}, {28'h0, flags()}, {28'h0, exp_ocnz});
  endtask

  // Write one word to data memory through the store pass-through path.
  task automatic dm_write(input logic [8:0] addr, input logic [15:0] data);
    alu_a = data; alu_store = 1'b1; dm_store = 1'b1; dm_address = addr;
    tick();
    dm_store = 1'b0; alu_store = 1'b0;
  endtask

  localparam logic [15:0] PROG [3] = '{16'hFFFF, 16'h4004, 16'h7000};

  initial begin
    reset = 1'b1; im_en_write = 1'b0; im_address = '0; im_data_in = '0;
    alu_a = '0; alu_b = '0; alu_opcode = '0; alu_store = 1'b0;
    dm_load = 1'b0; dm_store = 1'b0; dm_push = 1'b0; dm_pop = 1'b0;
    dm_sp = '0; dm_address = '0;
    @(negedge clk);
    tick();
    reset = 1'b0;
    #1;
    check("reset addr_reg", {23'h0, dm_address_reg}, 32'h0);
    check("idle dm_data_out", {16'h0, dm_data_out}, 32'h0);

    // IM download then fetch back
    for (int i = 0; i < 3; i++) begin
      im_en_write = 1'b1; im_address = 10'(i); im_data_in = PROG[i];
      tick();
    end
    im_en_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      im_address = 10'(i); #1;
      check($sformatf("im fetch %0d", i), {16'h0, instruction}, {16'h0, PROG[i]});
    end
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      im_address = 10'(i); #1;
      check($sformatf("im after reset %0d", i), {16'h0, instruction}, {16'h0, PROG[i]});
    end
    // old word visible until the write edge
    im_address = 10'd1; im_data_in = 16'h5555; im_en_write = 1'b1; #1;
    check("im old before edge", {16'h0, instruction}, 32'h4004);
    tick(); im_en_write = 1'b0; #1;
    check("im new after edge", {16'h0, instruction}, 32'h5555);

    // ALU vectors: expected {O,C,N,Z}
    alu_chk("add ovf",  16'h7FFF, 16'h0001, 6'd16, 1'b0, 16'h8000, 4'b1010);
    alu_chk("add carry",16'hFFFF, 16'h0001, 6'd16, 1'b0, 16'h0000, 4'b0101);
    alu_chk("sub borrow",16'h0000,16'h0001, 6'd17, 1'b0, 16'hFFFF, 4'b0110);
    alu_chk("cmp borrow",16'h0000,16'h0001, 6'd30, 1'b0, 16'h0000, 4'b0110);
    alu_chk("and",      16'h00F0, 16'hFF00, 6'd26, 1'b0, 16'h0000, 4'b0001);
    alu_chk("xor",      16'h00F0, 16'hFF00, 6'd28, 1'b0, 16'hFFF0, 4'b0010);
    alu_chk("not",      16'h00F0, 16'hFF00, 6'd29, 1'b0, 16'hFF0F, 4'b0010);
    alu_chk("op0",      16'h00F0, 16'hFF00, 6'd0,  1'b0, 16'h0000, 4'b0000);
    alu_chk("op63",     16'h1234, 16'h0001, 6'd63, 1'b0, 16'h0000, 4'b0000);
    alu_chk("tst",      16'h00F0, 16'hFF00, 6'd31, 1'b0, 16'h0000, 4'b0001);
    alu_chk("div0",     16'h1234, 16'h0000, 6'd24, 1'b0, 16'hFFFF, 4'b0110);
    alu_chk("mod0",     16'h1234, 16'h0000, 6'd25, 1'b0, 16'h1234, 4'b0100);
    alu_chk("div",      16'h0064, 16'h0007, 6'd24, 1'b0, 16'h000E, 4'b0000);
    alu_chk("mod",      16'h0064, 16'h0007, 6'd25, 1'b0, 16'h0002, 4'b0000);
    alu_chk("lsr",      16'h0003, 16'h0001, 6'd18, 1'b0, 16'h0001, 4'b0100);
    alu_chk("lsl amt0", 16'h8000, 16'h0000, 6'd19, 1'b0, 16'h8000, 4'b0010);
    alu_chk("lsl",      16'h8001, 16'h0001, 6'd19, 1'b0, 16'h0002, 4'b0100);
    alu_chk("ror",      16'h0001, 16'h0004, 6'd20, 1'b0, 16'h1000, 4'b0000);
    alu_chk("rol",      16'h8001, 16'h0001, 6'd21, 1'b0, 16'h0003, 4'b0100);
    alu_chk("mov",      16'h1111, 16'hFFFE, 6'd22, 1'b0, 16'hFFFE, 4'b0010);
    alu_chk("mul",      16'h0100, 16'h0100, 6'd23, 1'b0, 16'h0000, 4'b0001);
    alu_chk("or",       16'h00F0, 16'h0F00, 6'd27, 1'b0, 16'h0FF0, 4'b0000);
    alu_chk("inc ovf",  16'h7FFF, 16'h0000, 6'd32, 1'b0, 16'h8000, 4'b1010);
    alu_chk("dec borrow",16'h0000,16'h0000, 6'd33, 1'b0, 16'hFFFF, 4'b0110);
    alu_chk("dec ovf",  16'h8000, 16'h0000, 6'd33, 1'b0, 16'h7FFF, 4'b1000);
    alu_chk("store",    16'h8000, 16'h8000, 6'd16, 1'b1, 16'h8000, 4'b0000);
    alu_store = 1'b0;

    // DM direct store/load
    dm_write(9'd5, 16'h1234);
    dm_load = 1'b1; dm_address = 9'd5; #1;
    check("dm load", {16'h0, dm_data_out}, 32'h1234);
    check("addr_reg store", {23'h0, dm_address_reg}, 32'd5);
    dm_load = 1'b0; dm_address = 9'd7; tick();
    check("addr_reg hold", {23'h0, dm_address_reg}, 32'd5);
    check("dm idle zero", {16'h0, dm_data_out}, 32'h0);

    // DM stack
    dm_write(9'd0, 16'h00AA);
    dm_write(9'h010, 16'h0C0C);
    alu_a = 16'hBEEF; alu_store = 1'b1; dm_sp = 16'h01FF; dm_push = 1'b1;
    tick();
    dm_push = 1'b0; alu_store = 1'b0;
    dm_sp = 16'h01FE; dm_pop = 1'b1; #1;
    check("pop", {16'h0, dm_data_out}, 32'hBEEF);
    dm_load = 1'b1; dm_address = 9'd5; #1;
    check("pop over load", {16'h0, dm_data_out}, 32'hBEEF);
    dm_load = 1'b0;
    dm_sp = 16'h01FF; #1;
    check("pop wrap", {16'h0, dm_data_out}, 32'h00AA);
    dm_pop = 1'b0;

    // push and store together: only the store lands
    alu_a = 16'h7777; alu_store = 1'b1; dm_sp = 16'h0010; dm_push = 1'b1;
    dm_store = 1'b1; dm_address = 9'd5;
    tick();
    dm_push = 1'b0; dm_store = 1'b0; alu_store = 1'b0;
    dm_load = 1'b1; dm_address = 9'd5; #1;
    check("store wins", {16'h0, dm_data_out}, 32'h7777);
    dm_load = 1'b0; dm_pop = 1'b1; dm_sp = 16'h000F; #1;
    check("push dropped", {16'h0, dm_data_out}, 32'h0C0C);
    dm_pop = 1'b0;

    // reset beats capture
    reset = 1'b1; dm_load = 1'b1; dm_address = 9'd9;
    tick();
    check("reset over load", {23'h0, dm_address_reg}, 32'h0);
    reset = 1'b0; dm_load = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
